// File: rtl/seq_ctrl_defs_pkg.sv
// seq_ctrl_defs: shared definitions for the 101101 detector run controller.
//   state_e    : controller FSM encoding (3-bit, fixed values)
//   MODE_*     : detector mode encoding driven on det_m
//   DEF_WIDTH  : default test word width
//   DEF_CNT_W  : default match counter width
package seq_ctrl_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic MODE_MOORE = 1'b0;
  localparam logic MODE_MEALY = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/seq_detect_controller_rise_detect.sv
// rise_detect: registered copy of a level input and its rising-edge pulse.
//   clk   : clock
//   reset : async active-low reset
//   in    : level input (the start button)
//   rise  : in & ~in_q
// The history register resets to 1 so a button already held when reset
// releases is not seen as a fresh press.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) in_q <= 1'b1;
    else        in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/seq_detect_controller.sv
// seq_detect_controller: run controller for the 101101 serial detector.
// Loads a WIDTH-bit word and mode on a start rise, holds the detector
// cleared for one cycle, shifts the word out MSB-first on det_x, gives one
// flush cycle for a trailing Moore output, then reports a saturating count
// of det_z pulses with done.
//   clk, reset         : clock, async active-low reset
//   start, mode, word  : run request (level, rise-triggered), mode, pattern
//   det_z              : detector Z
//   det_x, det_m       : serial bit / latched mode to detector
//   det_clear          : hold detector in reset
//   busy, done         : run in progress / result valid
//   match_cnt, bit_idx : match count, index of bit on det_x
// Optional (macro SEQ_CTRL_MATCH_MAP_EN): match_map, one bit per bit index
// that completed a counted match.
module seq_detect_controller
  import seq_ctrl_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [WIDTH-1:0]           word,
  input  logic                       det_z,
  output logic                       det_x,
  output logic                       det_m,
  output logic                       det_clear,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(WIDTH+1)-1:0] bit_idx
`ifdef SEQ_CTRL_MATCH_MAP_EN
  ,
  output logic [WIDTH-1:0]           match_map
`endif
);

  localparam int IDX_W = $clog2(WIDTH+1);

  state_e           state, nxt;
  logic             rise;
  logic [WIDTH-1:0] shift_reg;
  logic             z_seen;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .in    (start),
    .rise  (rise)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    det_x     = 1'b0;
    det_clear = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (rise) nxt = ST_ARM;
      ST_ARM: begin
        busy = 1'b1;
        nxt  = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        det_clear = 1'b0;
        det_x     = shift_reg[WIDTH-1];
        if (bit_idx == IDX_W'(WIDTH-1)) nxt = ST_FLUSH;
      end
      // det_x stays 0; detector runs one more clock so a Moore match on
      // the last bit becomes visible on det_z.
      ST_FLUSH: begin
        busy      = 1'b1;
        det_clear = 1'b0;
        nxt       = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (rise) nxt = ST_ARM;
      end
      default:  nxt = ST_IDLE;
    endcase
  end

  // Z is only meaningful while the detector is out of clear.
  assign z_seen = det_z & ((state == ST_SHIFT) | (state == ST_FLUSH));

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      det_m     <= MODE_MOORE;
      match_cnt <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (rise) begin
            shift_reg <= word;
            det_m     <= mode;
          end
        end
        ST_ARM: begin
          match_cnt <= '0;
          bit_idx   <= '0;
        end
        ST_SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          bit_idx   <= bit_idx + IDX_W'(1);
        end
        default: ;
      endcase
      // Saturate rather than wrap.
      if (z_seen && (match_cnt != {CNT_W{1'b1}}))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

`ifdef SEQ_CTRL_MATCH_MAP_EN
  // Mealy Z belongs to the bit on det_x now; Moore Z lags one clock, so it
  // belongs to the previous bit (FLUSH, bit_idx==WIDTH, maps to WIDTH-1).
  logic [IDX_W-1:0] map_idx;
  logic             map_ok;

  always_comb begin
    map_idx = bit_idx;
    map_ok  = bit_idx < IDX_W'(WIDTH);
    if (det_m == MODE_MOORE) begin
      map_idx = bit_idx - IDX_W'(1);
      map_ok  = bit_idx != '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  match_map <= '0;
    else if (state == ST_ARM)    match_map <= '0;
    else if (z_seen && map_ok)   match_map <= match_map | (WIDTH'(1) << map_idx);
  end
`endif

endmodule

// File: tb/tb_seq_detect_controller.sv
module tb_seq_detect_controller;
  import seq_ctrl_defs::*;

  localparam int W   = 16;
  localparam int CW  = 4;
  localparam int W2  = 48;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, mode = MODE_MOORE;
  logic [W-1:0] word = '0;
  logic det_z, det_x, det_m, det_clear, busy, done;
  logic [CW-1:0] match_cnt;
  logic [$clog2(W+1)-1:0] bit_idx;

  logic start2 = 1'b0, mode2 = MODE_MOORE;
  logic [W2-1:0] word2 = '0;
  logic det_z2, det_x2, det_m2, det_clear2, busy2, done2;
  logic [CW2-1:0] match_cnt2;
  logic [$clog2(W2+1)-1:0] bit_idx2;
`ifdef SEQ_CTRL_MATCH_MAP_EN
  logic [W-1:0]  match_map;
  logic [W2-1:0] match_map2;
`endif

  seq_detect_controller #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .word(word),
    .det_z(det_z), .det_x(det_x), .det_m(det_m), .det_clear(det_clear),
    .busy(busy), .done(done), .match_cnt(match_cnt), .bit_idx(bit_idx)
`ifdef SEQ_CTRL_MATCH_MAP_EN
    , .match_map(match_map)
`endif
  );

  seq_detect_controller #(.WIDTH(W2), .CNT_W(CW2)) u_dut48 (
    .clk(clk), .reset(reset), .start(start2), .mode(mode2), .word(word2),
    .det_z(det_z2), .det_x(det_x2), .det_m(det_m2), .det_clear(det_clear2),
    .busy(busy2), .done(done2), .match_cnt(match_cnt2), .bit_idx(bit_idx2)
`ifdef SEQ_CTRL_MATCH_MAP_EN
    , .match_map(match_map2)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---- behavioural 101101 detector, non-overlapping
  // 0:"" 1:"1" 2:"10" 3:"101" 4:"1011" 5:"10110" 6:matched (Moore only)
  function automatic logic [2:0] dnext(input logic [2:0] s, input logic x, input logic m);
    case (s)
      3'd0: dnext = x ? 3'd1 : 3'd0;
      3'd1: dnext = x ? 3'd1 : 3'd2;
      3'd2: dnext = x ? 3'd3 : 3'd0;
      3'd3: dnext = x ? 3'd4 : 3'd2;
      3'd4: dnext = x ? 3'd1 : 3'd5;
      3'd5: dnext = x ? (m ? 3'd0 : 3'd6) : 3'd0;
      3'd6: dnext = x ? 3'd1 : 3'd0;
      default: dnext = 3'd0;
    endcase
  endfunction

  logic [2:0] ds, ds2;
  always @(posedge clk or negedge reset)
    if (!reset)         ds <= 3'd0;
    else if (det_clear) ds <= 3'd0;
    else                ds <= dnext(ds, det_x, det_m);
  always @(posedge clk or negedge reset)
    if (!reset)          ds2 <= 3'd0;
    else if (det_clear2) ds2 <= 3'd0;
    else                 ds2 <= dnext(ds2, det_x2, det_m2);
  assign det_z  = det_m  ? (ds  == 3'd5 && det_x)  : (ds  == 3'd6);
  assign det_z2 = det_m2 ? (ds2 == 3'd5 && det_x2) : (ds2 == 3'd6);

  // ---- scoreboard
  typedef struct {
    logic [CW-1:0] cnt;
    logic [W-1:0]  map;
    logic [W-1:0]  xseq;
    logic          m;
    int            done_cyc;
  } exp_t;
  typedef struct {
    logic [CW2-1:0] cnt;
    int             done_cyc;
  } exp2_t;
  exp_t  q[$];
  exp2_t q2[$];

  // monitor, main instance
  initial begin
    logic [W-1:0] xlog = '0;
    int xn = 0;
    logic done_d = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy && !det_clear && bit_idx < W) begin
        xlog = {xlog[W-2:0], det_x};
        xn++;
      end
      if (done && !done_d) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected no run", cyc);
        end else begin
          e = q.pop_front();
          chk("match_cnt", match_cnt, e.cnt);
          chk("done_latency", cyc, e.done_cyc);
          chk("det_x_seq", xlog, e.xseq);
          chk("shift_cycles", xn, W);
          chk("det_m_held", det_m, e.m);
          chk("bit_idx_done", bit_idx, W);
`ifdef SEQ_CTRL_MATCH_MAP_EN
          chk("match_map", match_map, e.map);
`endif
        end
      end
      if (!busy) begin xlog = '0; xn = 0; end
      done_d = done;
    end
  end

  // monitor, 48-bit instance
  initial begin
    logic done_d = 1'b0;
    exp2_t e;
    forever begin
      @(negedge clk);
      if (done2 && !done_d) begin
        if (q2.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done48: got done at cycle %0d, expected no run", cyc);
        end else begin
          e = q2.pop_front();
          chk("match_cnt48_sat", match_cnt2, e.cnt);
          chk("done_latency48", cyc, e.done_cyc);
          chk("bit_idx48_done", bit_idx2, W2);
        end
      end
      done_d = done2;
    end
  end

  // ---- stimulus helpers
  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  // E0 is the next posedge (cyc+1); done expected at E0+W+2.
  task automatic run(input logic [W-1:0] w, input logic m, input logic [CW-1:0] c,
                     input logic [W-1:0] map);
    @(negedge clk);
    word = w; mode = m; start = 1'b1;
    q.push_back('{cnt: c, map: map, xseq: w, m: m, done_cyc: cyc + 1 + W + 2});
    @(negedge clk);
    start = 1'b0;
    wait_done("run", 40);
  endtask

  initial begin
    #2 reset = 1'b0;
    start = 1'b1;                       // button held through reset release
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_det_clear", det_clear, 1);
    chk("rst_det_x", det_x, 0);
    chk("rst_det_m", det_m, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_bit_idx", bit_idx, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("held_start_no_run", busy | done, 0);
    start = 1'b0;
    @(negedge clk);

    run(16'hB6D0, MODE_MOORE, 4'd2, 16'h0820);
    run(16'hB6D0, MODE_MEALY, 4'd2, 16'h0820);
    run(16'h0000, MODE_MOORE, 4'd0, 16'h0000);
    run(16'h0000, MODE_MEALY, 4'd0, 16'h0000);
    run(16'hFFFF, MODE_MOORE, 4'd0, 16'h0000);
    run(16'hFFFF, MODE_MEALY, 4'd0, 16'h0000);
    run(16'h002D, MODE_MOORE, 4'd1, 16'h8000); // match completes in FLUSH
    run(16'h002D, MODE_MEALY, 4'd1, 16'h8000); // match on last SHIFT bit

    // start held for 40 cycles: exactly one run
    @(negedge clk);
    word = 16'hB6D0; mode = MODE_MOORE; start = 1'b1;
    q.push_back('{cnt: 4'd2, map: 16'h0820, xseq: 16'hB6D0, m: MODE_MOORE, done_cyc: cyc + 1 + W + 2});
    repeat (40) @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_idle", busy, 0);
    start = 1'b0;
    @(negedge clk);

    // start/mode/word toggled during SHIFT are ignored
    @(negedge clk);
    word = 16'hB6D0; mode = MODE_MOORE; start = 1'b1;
    q.push_back('{cnt: 4'd2, map: 16'h0820, xseq: 16'hB6D0, m: MODE_MOORE, done_cyc: cyc + 1 + W + 2});
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    mode = MODE_MEALY; word = 16'hFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; mode = MODE_MOORE;
    @(negedge clk); start = 1'b0; mode = MODE_MEALY;
    wait_done("toggle", 40);
    mode = MODE_MOORE;

    // reset at the 7th SHIFT cycle (Mealy match at bit 5 already counted)
    @(negedge clk);
    word = 16'hB6D0; mode = MODE_MEALY; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40 && !(busy && !det_clear && bit_idx == 6); i++) @(negedge clk);
    chk("abort_reached_shift7", busy && !det_clear && bit_idx == 6, 1);
    chk("abort_pre_cnt", match_cnt, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_det_clear", det_clear, 1);
    chk("abort_match_cnt", match_cnt, 0);
    chk("abort_bit_idx", bit_idx, 0);
    chk("abort_det_m", det_m, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle", busy | done, 0);
    run(16'hB6D0, MODE_MEALY, 4'd2, 16'h0820);

    // 48-bit instance: eight matches saturate a 2-bit counter at 3
    @(negedge clk);
    word2 = {8{6'b101101}}; mode2 = MODE_MOORE; start2 = 1'b1;
    q2.push_back('{cnt: 2'd3, done_cyc: cyc + 1 + W2 + 2});
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 80 && !done2; i++) @(negedge clk);
    if (!done2) chk("run48_timeout", 0, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("scoreboard48_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
